// File: rtl/pong_ball_ctrl_if.sv
// Signal bundle between the pong game sequencer and its surroundings.
// The master side supplies the serve request and the cell positions of the ball and paddles.
// The slave side (the sequencer) returns the ball steering and the score state.
interface pong_ball_ctrl_if #(
  parameter int THETA_WIDTH = 6
);

  logic                   serve;
  logic [3:0]             ball_x;
  logic [3:0]             ball_y;
  logic [3:0]             paddle_l;
  logic [3:0]             paddle_r;

  logic                   ball_reset;
  logic [THETA_WIDTH-1:0] theta;
  logic signed [4:0]      speed;
  logic [3:0]             score_l;
  logic [3:0]             score_r;
  logic                   game_over;

  modport master (
    output serve, ball_x, ball_y, paddle_l, paddle_r,
    input  ball_reset, theta, speed, score_l, score_r, game_over
  );

  modport slave (
    input  serve, ball_x, ball_y, paddle_l, paddle_r,
    output ball_reset, theta, speed, score_l, score_r, game_over
  );

endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong game sequencer.
// Each game tick it inspects the ball and paddle cells and decides wall bounces, paddle hits and misses.
// It steers the ball datapath through heading, speed and recentre, and runs the serve/play/score/game-over flow.
// All outputs are registered, so a decision taken in cycle N is visible in cycle N+1.
module pong_ball_ctrl #(
  parameter int THETA_WIDTH = 6,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 15,
  parameter int PADDLE_H    = 3,
  parameter int SERVE_ANGLE = 4,
  parameter int SCORE_HOLD  = 500,
  parameter int WIN_SCORE   = 9
) (
  input  logic            clk,
  input  logic            reset,
  pong_ball_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_SCORE,
    ST_GAMEOVER
  } state_e;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_e;

  localparam int HOLD_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

  localparam logic [HOLD_W-1:0]      HOLD_LAST   = HOLD_W'(SCORE_HOLD - 1);
  localparam logic [THETA_WIDTH-1:0] QTR_TURN    = THETA_WIDTH'(1 << (THETA_WIDTH - 2));
  localparam logic [THETA_WIDTH-1:0] HALF_TURN   = THETA_WIDTH'(1 << (THETA_WIDTH - 1));
  localparam logic [THETA_WIDTH-1:0] THREE_QTR   = THETA_WIDTH'(3 << (THETA_WIDTH - 2));
  localparam logic [THETA_WIDTH-1:0] SERVE_RIGHT = THETA_WIDTH'(SERVE_ANGLE);
  localparam logic [THETA_WIDTH-1:0] SERVE_LEFT  = HALF_TURN - SERVE_RIGHT;
  localparam logic signed [4:0]      SPEED_START = 5'(SPEED_INIT);
  localparam logic signed [4:0]      SPEED_CEIL  = 5'(SPEED_MAX);
  localparam logic [4:0]             PAD_EXTENT  = 5'(PADDLE_H - 1);
  localparam logic [3:0]             WIN_POINTS  = 4'(WIN_SCORE);
  localparam logic [3:0]             LAST_CELL   = 4'd15;

  state_e                 state_q,      state_d;
  dir_e                   next_dir_q,   next_dir_d;
  logic                   x_lock_q,     x_lock_d;
  logic                   y_lock_q,     y_lock_d;
  logic [HOLD_W-1:0]      hold_cnt_q,   hold_cnt_d;
  logic                   ball_reset_q, ball_reset_d;
  logic [THETA_WIDTH-1:0] theta_q,      theta_d;
  logic signed [4:0]      speed_q,      speed_d;
  logic [3:0]             score_l_q,    score_l_d;
  logic [3:0]             score_r_q,    score_r_d;
  logic                   game_over_q,  game_over_d;

  // Heading quadrant decode; exact verticals/horizontals belong to neither side.
  logic moving_right, moving_left, moving_down, moving_up;
  assign moving_right = (theta_q < QTR_TURN) || (theta_q > THREE_QTR);
  assign moving_left  = (theta_q > QTR_TURN) && (theta_q < THREE_QTR);
  assign moving_down  = (theta_q != '0) && (theta_q < HALF_TURN);
  assign moving_up    = (theta_q > HALF_TURN);

  logic on_x_edge, on_y_edge;
  assign on_x_edge = (bus.ball_x == 4'd0) || (bus.ball_x == LAST_CELL);
  assign on_y_edge = (bus.ball_y == 4'd0) || (bus.ball_y == LAST_CELL);

  // Paddle span on the column the ball sits in, clipped to the bottom row.
  logic [3:0] pad_top, pad_bot;
  logic [4:0] pad_bot_raw;
  logic       in_span;
  assign pad_top     = (bus.ball_x == 4'd0) ? bus.paddle_l : bus.paddle_r;
  assign pad_bot_raw = {1'b0, pad_top} + PAD_EXTENT;
  assign pad_bot     = (pad_bot_raw > {1'b0, LAST_CELL}) ? LAST_CELL : pad_bot_raw[3:0];
  assign in_span     = (bus.ball_y >= pad_top) && (bus.ball_y <= pad_bot);

  logic edge_l, edge_r, pad_hit, miss, wall_hit;
  assign edge_l   = !x_lock_q && (bus.ball_x == 4'd0) && moving_left;
  assign edge_r   = !x_lock_q && (bus.ball_x == LAST_CELL) && moving_right;
  assign pad_hit  = (edge_l || edge_r) && in_span;
  assign miss     = (edge_l || edge_r) && !in_span;
  assign wall_hit = !y_lock_q &&
                    (((bus.ball_y == 4'd0) && moving_up) || ((bus.ball_y == LAST_CELL) && moving_down));

  logic signed [4:0] speed_inc;
  logic [3:0]        score_l_inc, score_r_inc;
  assign speed_inc   = (speed_q < SPEED_CEIL) ? speed_q + 5'sd1 : speed_q;
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  // Next-state and next-output logic for the game flow.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    next_dir_d   = next_dir_q;
    x_lock_d     = x_lock_q;
    y_lock_d     = y_lock_q;
    hold_cnt_d   = hold_cnt_q;
    ball_reset_d = ball_reset_q;
    theta_d      = theta_q;
    speed_d      = speed_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    game_over_d  = game_over_q;

    unique case (state_q)
      ST_IDLE: begin
        ball_reset_d = 1'b1;
        speed_d      = '0;
        if (bus.serve) state_d = ST_SERVE;
      end

      ST_SERVE: begin
        theta_d      = (next_dir_q == DIR_RIGHT) ? SERVE_RIGHT : SERVE_LEFT;
        speed_d      = SPEED_START;
        ball_reset_d = 1'b0;
        x_lock_d     = 1'b0;
        y_lock_d     = 1'b0;
        state_d      = ST_PLAY;
      end

      ST_PLAY: begin
        // Locks only hold while the ball still sits on the cell that set them.
        x_lock_d = x_lock_q && on_x_edge;
        y_lock_d = y_lock_q && on_y_edge;
        if (miss) begin
          // A miss outranks a same-cycle wall bounce; heading is left alone.
          ball_reset_d = 1'b1;
          speed_d      = '0;
          hold_cnt_d   = '0;
          if (edge_l) begin
            score_r_d   = score_r_inc;
            next_dir_d  = DIR_RIGHT;
            game_over_d = (score_r_inc == WIN_POINTS);
          end else begin
            score_l_d   = score_l_inc;
            next_dir_d  = DIR_LEFT;
            game_over_d = (score_l_inc == WIN_POINTS);
          end
          state_d = game_over_d ? ST_GAMEOVER : ST_SCORE;
        end else if (wall_hit && pad_hit) begin
          theta_d  = HALF_TURN + theta_q;
          speed_d  = speed_inc;
          x_lock_d = 1'b1;
          y_lock_d = 1'b1;
        end else if (wall_hit) begin
          theta_d  = '0 - theta_q;
          y_lock_d = 1'b1;
        end else if (pad_hit) begin
          theta_d  = HALF_TURN - theta_q;
          speed_d  = speed_inc;
          x_lock_d = 1'b1;
        end
      end

      ST_SCORE: begin
        ball_reset_d = 1'b1;
        speed_d      = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_GAMEOVER: begin
        ball_reset_d = 1'b1;
        speed_d      = '0;
        game_over_d  = 1'b1;
        if (bus.serve) begin
          score_l_d   = '0;
          score_r_d   = '0;
          game_over_d = 1'b0;
          next_dir_d  = DIR_RIGHT;
          state_d     = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
    if (reset) begin
      state_q      <= ST_IDLE;
      next_dir_q   <= DIR_RIGHT;
      x_lock_q     <= 1'b0;
      y_lock_q     <= 1'b0;
      hold_cnt_q   <= '0;
      ball_reset_q <= 1'b1;
      theta_q      <= SERVE_RIGHT;
      speed_q      <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_dir_q   <= next_dir_d;
      x_lock_q     <= x_lock_d;
      y_lock_q     <= y_lock_d;
      hold_cnt_q   <= hold_cnt_d;
      ball_reset_q <= ball_reset_d;
      theta_q      <= theta_d;
      speed_q      <= speed_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.ball_reset = ball_reset_q;
  assign bus.theta      = theta_q;
  assign bus.speed      = speed_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for the pong game sequencer.
// A rule-level game model predicts every output every cycle.
// Directed scenarios walk through serve, bounces, saturation, scoring, game over and reset.
// A randomized phase then throws arbitrary ball/paddle cells and serves at it.
module tb_pong_ball_ctrl;

  localparam int SPEED_INIT  = 4;
  localparam int SPEED_MAX   = 15;
  localparam int PADDLE_H    = 3;
  localparam int SERVE_ANGLE = 4;
  localparam int SCORE_HOLD  = 500;
  localparam int WIN_SCORE   = 9;

  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_SCORE = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic reset;

  pong_ball_ctrl_if #(.THETA_WIDTH(6)) bus ();

  pong_ball_ctrl #(
    .THETA_WIDTH(6), .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX), .PADDLE_H(PADDLE_H),
    .SERVE_ANGLE(SERVE_ANGLE), .SCORE_HOLD(SCORE_HOLD), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference game state, kept as plain integers.
  int m_phase, m_theta, m_speed, m_br, m_sl, m_sr, m_go, m_next_right, m_xl, m_yl, m_hold;

  task automatic check(input string tag, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int wrap64(input int v);
    return ((v % 64) + 64) % 64;
  endfunction

  // Apply the game rules for one tick using the inputs present at the clock edge.
  task automatic model_step();
    int x, y, top, bot;
    bit right, left, down, up, wall, el, er, pad, miss;
    if (reset) begin
      m_phase = P_IDLE; m_br = 1; m_theta = SERVE_ANGLE; m_speed = 0;
      m_sl = 0; m_sr = 0; m_go = 0; m_next_right = 1; m_xl = 0; m_yl = 0; m_hold = 0;
    end else begin
      x = bus.ball_x;
      y = bus.ball_y;
      case (m_phase)
        P_IDLE: begin
          m_br = 1; m_speed = 0;
          if (bus.serve) m_phase = P_SERVE;
        end
        P_SERVE: begin
          m_theta = m_next_right ? SERVE_ANGLE : 32 - SERVE_ANGLE;
          m_speed = SPEED_INIT; m_br = 0; m_xl = 0; m_yl = 0;
          m_phase = P_PLAY;
        end
        P_PLAY: begin
          right = (m_theta <= 15) || (m_theta >= 49);
          left  = (m_theta >= 17) && (m_theta <= 47);
          down  = (m_theta >= 1) && (m_theta <= 31);
          up    = (m_theta >= 33);
          wall  = !m_yl && ((y == 0 && up) || (y == 15 && down));
          el    = !m_xl && x == 0 && left;
          er    = !m_xl && x == 15 && right;
          top   = (x == 0) ? int'(bus.paddle_l) : int'(bus.paddle_r);
          bot   = (top + PADDLE_H - 1 > 15) ? 15 : top + PADDLE_H - 1;
          pad   = (el || er) && (y >= top) && (y <= bot);
          miss  = (el || er) && !((y >= top) && (y <= bot));
          if (x != 0 && x != 15) m_xl = 0;
          if (y != 0 && y != 15) m_yl = 0;
          if (miss) begin
            m_br = 1; m_speed = 0; m_hold = 0;
            if (el) begin m_sr++; m_next_right = 1; end
            else    begin m_sl++; m_next_right = 0; end
            if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
              m_phase = P_OVER; m_go = 1;
            end else begin
              m_phase = P_SCORE;
            end
          end else if (wall || pad) begin
            if (wall && pad)  m_theta = wrap64(32 + m_theta);
            else if (wall)    m_theta = wrap64(-m_theta);
            else              m_theta = wrap64(32 - m_theta);
            if (pad) begin
              m_speed = (m_speed + 1 > SPEED_MAX) ? SPEED_MAX : m_speed + 1;
              m_xl = 1;
            end
            if (wall) m_yl = 1;
          end
        end
        P_SCORE: begin
          m_br = 1; m_speed = 0;
          m_hold++;
          if (m_hold == SCORE_HOLD) m_phase = P_IDLE;
        end
        default: begin
          m_br = 1; m_speed = 0; m_go = 1;
          if (bus.serve) begin
            m_sl = 0; m_sr = 0; m_go = 0; m_next_right = 1; m_phase = P_SERVE;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("ball_reset", int'(bus.ball_reset), m_br);
    check("theta",      int'(bus.theta),      m_theta);
    check("speed",      int'(bus.speed),      m_speed);
    check("score_l",    int'(bus.score_l),    m_sl);
    check("score_r",    int'(bus.score_r),    m_sr);
    check("game_over",  int'(bus.game_over),  m_go);
  endtask

  // One clock: update the model at the edge, then compare once outputs have settled.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_serve();
    bus.serve = 1'b1;
    tick();
    bus.serve = 1'b0;
  endtask

  task automatic place(input int x, input int y);
    bus.ball_x = 4'(x);
    bus.ball_y = 4'(y);
  endtask

  task automatic hold_score();
    for (int k = 1; k <= SCORE_HOLD; k++) tick();
  endtask

  initial begin
    m_phase = P_IDLE; m_br = 1; m_theta = SERVE_ANGLE; m_speed = 0;
    m_sl = 0; m_sr = 0; m_go = 0; m_next_right = 1; m_xl = 0; m_yl = 0; m_hold = 0;
    reset = 1'b1;
    bus.serve = 1'b0;
    place(8, 8);
    bus.paddle_l = 4'd6;
    bus.paddle_r = 4'd6;

    // Reset state.
    tick();
    tick();
    check("rst_ball_reset", int'(bus.ball_reset), 1);
    check("rst_theta",      int'(bus.theta),      4);
    check("rst_speed",      int'(bus.speed),      0);
    check("rst_game_over",  int'(bus.game_over),  0);
    reset = 1'b0;

    // Serve: SERVE cycle, then play outputs.
    pulse_serve();
    check("serve_still_reset", int'(bus.ball_reset), 1);
    tick();
    check("play_theta",      int'(bus.theta),      4);
    check("play_speed",      int'(bus.speed),      4);
    check("play_ball_reset", int'(bus.ball_reset), 0);

    // Bottom wall bounce, exactly once while parked on row 15.
    place(8, 14); tick();
    place(8, 15); tick();
    check("wall_flip", int'(bus.theta), 60);
    tick();
    check("wall_no_reflip", int'(bus.theta), 60);
    place(8, 14); tick();
    place(8, 0);  tick();
    check("top_wall_flip", int'(bus.theta), 4);
    place(8, 7);  tick();

    // Right paddle hit, then 11 more alternating hits to saturate speed.
    place(15, 7); tick();
    check("pad_theta", int'(bus.theta), 28);
    check("pad_speed", int'(bus.speed), 5);
    for (int i = 1; i <= 11; i++) begin
      place(8, 7); tick();
      place((i % 2 == 1) ? 0 : 15, 7); tick();
    end
    check("speed_sat", int'(bus.speed), 15);
    check("sat_theta", int'(bus.theta), 4);

    // Corner: wall and paddle together.
    place(8, 14); tick();
    bus.paddle_r = 4'd13;
    place(15, 15); tick();
    check("corner_theta", int'(bus.theta), 36);
    check("corner_speed", int'(bus.speed), 15);
    tick();
    check("corner_locked", int'(bus.theta), 36);

    // Left miss: right player scores, hold, serve heads right.
    place(8, 8); tick();
    place(0, 2); tick();
    check("miss_score_r",    int'(bus.score_r),    1);
    check("miss_ball_reset", int'(bus.ball_reset), 1);
    for (int k = 1; k <= SCORE_HOLD; k++) begin
      bus.serve = (k == 10 || k == SCORE_HOLD);
      tick();
    end
    bus.serve = 1'b0;
    check("hold_ignores_serve", int'(bus.ball_reset), 1);
    pulse_serve();
    tick();
    check("reserve_theta", int'(bus.theta), 4);
    check("reserve_br",    int'(bus.ball_reset), 0);

    // Right player misses nine times: left reaches the winning score.
    bus.paddle_l = 4'd6;
    bus.paddle_r = 4'd8;
    for (int i = 0; i < 9; i++) begin
      place(8, 8); tick();
      place(15, 0); tick();
      if (i < 8) begin
        hold_score();
        pulse_serve();
        tick();
        check("serve_left_theta", int'(bus.theta), 28);
        place(8, 7); tick();
        place(0, 7); tick();
      end
    end
    check("win_score_l",   int'(bus.score_l),   9);
    check("win_score_r",   int'(bus.score_r),   1);
    check("win_game_over", int'(bus.game_over), 1);
    tick();
    check("over_frozen", int'(bus.score_l), 9);
    pulse_serve();
    check("over_cleared_l", int'(bus.score_l),   0);
    check("over_cleared_go", int'(bus.game_over), 0);
    tick();
    check("newgame_theta", int'(bus.theta), 4);

    // Reset mid-rally.
    place(8, 8); tick();
    reset = 1'b1;
    tick();
    check("midrst_br",    int'(bus.ball_reset), 1);
    check("midrst_speed", int'(bus.speed),      0);
    check("midrst_theta", int'(bus.theta),      4);
    reset = 1'b0;

    // Randomized play against the model.
    for (int c = 0; c < 20000; c++) begin
      int r;
      r = int'($urandom_range(0, 3));
      bus.ball_x   = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 3));
      bus.ball_y   = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      bus.paddle_l = 4'($urandom_range(0, 15));
      bus.paddle_r = 4'($urandom_range(0, 15));
      bus.serve    = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 2999) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
